uart_cmd_rx: RTL and testbench

// - UART receiver (8N1, LSB first, idle high) on the Segway RX pin; receiving end of the UART_tx command link.
// - Recovers command bytes from the BLE module ('g' = go, 's' = stop, ...) and hands them to the command/auth logic.
// - Handshake is rdy/clr_rdy; framing and overrun errors are flagged.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_cmd_rx.sv | 138 +++++++++++++
 tb/tb_uart_cmd_rx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the command-link transmitter and receiver.
// Receiver state encoding, frame width and the clocks-per-bit helper.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  function automatic int bit_clks(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// RX metastability synchronizer (2 flops) plus an edge-history flop; all preset to idle-high.
// Latency 2 clk to rx_s; rx_fall pulses once per synced 1->0 transition, no backpressure.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic rx_s,
  output logic rx_fall
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], rx_i};
    end
  end

  assign rx_s    = sync_q[1];
  assign rx_fall = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver for BLE command bytes; rdy/clr_rdy handshake with framing and overrun flags.
// rdy rises 9.5 bit times + 4 clk after the start edge; the consumer never stalls the line.
module uart_cmd_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 19_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr_err
);

  localparam int BIT_CLKS  = bit_clks(CLK_FREQ, BAUD);
  localparam int HALF_CLKS = BIT_CLKS / 2;
  // The zero count is itself a cycle, so BIT_CLKS-1 gives a tick period of exactly BIT_CLKS.
  localparam logic [11:0] BIT_LD  = 12'(BIT_CLKS - 1);
  localparam logic [11:0] HALF_LD = 12'(HALF_CLKS);

  rx_state_t   state_q, state_d;
  logic [11:0] baud_q, baud_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  data_q, data_d;
  logic        rdy_q, rdy_d;
  logic        frm_q, frm_d;
  logic        ovr_q, ovr_d;
  logic        unread_q, unread_d;
  logic        rx_s, rx_fall, tick;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_i   (RX),
    .rx_s   (rx_s),
    .rx_fall(rx_fall)
  );

  assign tick = (baud_q == 12'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      baud_q   <= 12'd0;
      bitcnt_q <= 4'd0;
      shreg_q  <= 8'h00;
      data_q   <= 8'h00;
      rdy_q    <= 1'b0;
      frm_q    <= 1'b0;
      ovr_q    <= 1'b0;
      unread_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      rdy_q    <= rdy_d;
      frm_q    <= frm_d;
      ovr_q    <= ovr_d;
      unread_q <= unread_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = tick ? baud_q : baud_q - 12'd1;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    rdy_d    = rdy_q;
    frm_d    = frm_q;
    ovr_d    = ovr_q;
    unread_d = unread_q;

    if (clr_rdy) begin
      rdy_d    = 1'b0;
      ovr_d    = 1'b0;
      unread_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (rx_fall) begin
          baud_d  = HALF_LD;
          rdy_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            baud_d   = BIT_LD;
            bitcnt_d = 4'd0;
            state_d  = DATA;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shreg_d  = {rx_s, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          baud_d   = BIT_LD;
          if (bitcnt_q == 4'(DATA_BITS - 1)) state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          if (rx_s) begin
            data_d   = shreg_q;
            rdy_d    = 1'b1;
            frm_d    = 1'b0;
            // rdy is dropped by the start edge, so overrun tracks an unacknowledged byte instead.
            ovr_d    = ovr_d | (unread_q & ~clr_rdy);
            unread_d = 1'b1;
          end else begin
            frm_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data = data_q;
  assign rdy     = rdy_q;
  assign frm_err = frm_q;
  assign ovr_err = ovr_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed + randomized bench for uart_cmd_rx at a fast baud (32 clk/bit) against a frame-level model.
module tb_uart_cmd_rx;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 1_562_500;
  localparam int BIT      = 32;
  localparam int HALF     = 16;
  localparam int LAT      = 9 * BIT + HALF + 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RX = 1'b1;
  logic       clr_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rdy, frm_err, ovr_err;

  int n_cmp = 0;
  int n_fail = 0;
  int lat = -1;

  logic [7:0] m_data;
  logic       m_rdy, m_frm, m_ovr, m_unread;

  uart_cmd_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .RX     (RX),
    .clr_rdy(clr_rdy),
    .rx_data(rx_data),
    .rdy    (rdy),
    .frm_err(frm_err),
    .ovr_err(ovr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check($sformatf("%s_data", tag), 32'(rx_data), 32'(m_data));
    check($sformatf("%s_rdy", tag), 32'(rdy), 32'(m_rdy));
    check($sformatf("%s_frm", tag), 32'(frm_err), 32'(m_frm));
    check($sformatf("%s_ovr", tag), 32'(ovr_err), 32'(m_ovr));
  endtask

  // Reference model, updated once per whole frame or handshake event.
  task automatic m_reset();
    m_data = 8'h00; m_rdy = 1'b0; m_frm = 1'b0; m_ovr = 1'b0; m_unread = 1'b0;
  endtask

  task automatic m_good(input logic [7:0] b);
    m_ovr    = m_ovr | m_unread;
    m_data   = b;
    m_rdy    = 1'b1;
    m_frm    = 1'b0;
    m_unread = 1'b1;
  endtask

  task automatic m_bad();
    m_rdy = 1'b0;
    m_frm = 1'b1;
  endtask

  task automatic m_clr();
    m_rdy = 1'b0; m_ovr = 1'b0; m_unread = 1'b0;
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop, input int per);
    @(posedge clk);
    #1;
    RX = 1'b0;
    hold(per);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      hold(per);
    end
    RX = stop;
    hold(per);
    RX = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input int per);
    drive_frame(b, stop, per);
    hold(2);
    if (stop) m_good(b);
    else m_bad();
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1;
    clr_rdy = 1'b1;
    hold(1);
    clr_rdy = 1'b0;
    m_clr();
  endtask

  initial begin
    logic [7:0] b;
    logic       stop;
    int         per;
    int         t_clr;

    m_reset();
    hold(3);
    check_all("reset");
    rst_n = 1'b1;
    hold(5);

    // Loopback 'g' with start-edge to rdy latency
    fork
      drive_frame(8'h67, 1'b1, BIT);
      begin
        @(posedge clk);
        #1;
        for (int c = 1; c <= 1000; c++) begin
          @(posedge clk);
          #1;
          if (rdy === 1'b1) begin
            lat = c;
            break;
          end
        end
      end
    join
    n_cmp++;
    assert (lat >= LAT - 1 && lat <= LAT + 1) else begin
      n_fail++;
      $error("FAIL latency: observed %0d expected %0d +/-1", lat, LAT);
    end
    hold(2);
    m_good(8'h67);
    check_all("loopback");

    pulse_clr();
    check("clr_rdy", 32'(rdy), 32'(m_rdy));
    check("clr_data", 32'(rx_data), 32'h67);

    // Short low pulse on the line must be rejected as a glitch
    RX = 1'b0;
    hold(HALF / 2);
    RX = 1'b1;
    m_rdy = 1'b0;
    hold(3 * BIT);
    check("glitch_rdy", 32'(rdy), 32'(m_rdy));
    check("glitch_frm", 32'(frm_err), 32'(m_frm));
    send(8'hA5, 1'b1, BIT);
    check_all("after_glitch");
    pulse_clr();

    send(8'h3C, 1'b0, BIT);
    check_all("frame_err");
    send(8'h3C, 1'b1, BIT);
    check_all("frame_recover");

    pulse_clr();
    send(8'h00, 1'b1, BIT);
    send(8'hFF, 1'b1, BIT);
    check_all("overrun");
    pulse_clr();
    check_all("overrun_clr");

    // clr_rdy coincident with stop-bit acceptance: the new byte wins, no overrun
    send(8'h11, 1'b1, BIT);
    t_clr = (lat > 1) ? lat : LAT;
    fork
      drive_frame(8'h22, 1'b1, BIT);
      begin
        @(posedge clk);
        #1;
        hold(t_clr - 1);
        clr_rdy = 1'b1;
        hold(1);
        clr_rdy = 1'b0;
        check("coinc_rdy", 32'(rdy), 32'h1);
        check("coinc_ovr", 32'(ovr_err), 32'h0);
      end
    join
    hold(2);
    m_clr();
    m_good(8'h22);
    check_all("coincident");

    // Reset after four data bits of 8'h55
    b = 8'h55;
    @(posedge clk);
    #1;
    RX = 1'b0;
    hold(BIT);
    for (int i = 0; i < 4; i++) begin
      RX = b[i];
      hold(BIT);
    end
    rst_n = 1'b0;
    #1;
    m_reset();
    check_all("mid_reset");
    RX = 1'b1;
    hold(3);
    rst_n = 1'b1;
    hold(2 * BIT);
    send(8'h55, 1'b1, BIT);
    check_all("post_reset");

    // Random frames, random stop bits, bit period within about +/-3%
    pulse_clr();
    for (int k = 0; k < 40; k++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 99) < 85);
      per  = BIT - 1 + int'($urandom_range(0, 2));
      send(b, stop, per);
      check_all($sformatf("rand%0d", k));
      if ($urandom_range(0, 2) == 0) begin
        pulse_clr();
        check($sformatf("rand%0d_clr", k), 32'(rdy), 32'(m_rdy));
      end
      hold(int'($urandom_range(1, 20)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
